// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;

    // Wide enough to be truncated to any supported data width.
    localparam logic [63:0] ERR_DATA = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wb_cmd_timeout.sv
// Bus-cycle watchdog: counts BUS cycles without ack and flags expiry on the last one.
module wb_cmd_timeout
    import wb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int unsigned CNT_W = max_u(8, $clog2(TIMEOUT_CYCLES + 1));

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the TIMEOUT_CYCLES-th ack-less BUS cycle.
    assign o_expired = i_count && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator with valid/ready command and response ports.
// Optional ack watchdog enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    input  logic              wb_ack_i,
    output logic              busy
);

    state_t            r_state, w_state_next;
    logic              r_cyc, w_cyc_next;
    logic              r_we, w_we_next;
    logic [ADDR_W-1:0] r_adr, w_adr_next;
    logic [DATA_W-1:0] r_dat, w_dat_next;
    logic [DATA_W-1:0] r_rsp_dat, w_rsp_dat_next;
    logic              r_rsp_err, w_rsp_err_next;
    logic              r_rsp_valid, w_rsp_valid_next;
    logic              w_start;
    logic              w_expired;

    assign w_start = (r_state == IDLE) && cmd_valid;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic w_count;

    assign w_count = (r_state == BUS) && !wb_ack_i;

    wb_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_start),
        .i_count  (w_count),
        .o_expired(w_expired)
    );
`else
    // No watchdog: BUS waits for ack forever.
    assign w_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cyc       <= w_cyc_next;
            r_we        <= w_we_next;
            r_adr       <= w_adr_next;
            r_dat       <= w_dat_next;
            r_rsp_dat   <= w_rsp_dat_next;
            r_rsp_err   <= w_rsp_err_next;
            r_rsp_valid <= w_rsp_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cyc_next       = r_cyc;
        w_we_next        = r_we;
        w_adr_next       = r_adr;
        w_dat_next       = r_dat;
        w_rsp_dat_next   = r_rsp_dat;
        w_rsp_err_next   = r_rsp_err;
        w_rsp_valid_next = r_rsp_valid;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_adr_next   = cmd_adr;
                    w_dat_next   = cmd_dat;
                    w_we_next    = cmd_we;
                    w_cyc_next   = 1'b1;
                    w_state_next = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a coincident timeout.
                if (wb_ack_i) begin
                    w_cyc_next       = 1'b0;
                    w_rsp_dat_next   = r_we ? '0 : wb_dat_i;
                    w_rsp_err_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = RESP;
                end else if (w_expired) begin
                    w_cyc_next       = 1'b0;
                    w_rsp_dat_next   = DATA_W'(ERR_DATA);
                    w_rsp_err_next   = 1'b1;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: begin
                w_cyc_next       = 1'b0;
                w_rsp_valid_next = 1'b0;
                w_state_next     = IDLE;
            end
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a registered-ack slave model and a response scoreboard.
module tb_wb_cmd_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [7:0] cmd_adr, cmd_dat;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_dat;
    logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic       wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic       busy;

    logic       s_en, s_ack, spur_ack;
    logic [7:0] mem [256];

    logic [8:0] sb_q [$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_viol = 0;
    logic       prev_ack = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_W        (8),
        .DATA_W        (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_ack_i (wb_ack_i),
        .busy     (busy)
    );

    // Registered-ack slave: ack one cycle after stb, never on two consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ack <= 1'b0;
        else        s_ack <= s_en && wb_cyc_o && wb_stb_o && !s_ack;
    end

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_we_o && s_ack) mem[wb_adr_o] <= wb_dat_o;
    end

    assign wb_ack_i = s_ack | spur_ack;
    assign wb_dat_i = mem[wb_adr_o];

    // Protocol monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_ack && wb_stb_o) n_viol++;
            if (cmd_ready && busy) n_viol++;
            if (wb_cyc_o && rsp_valid) n_viol++;
            prev_ack = wb_stb_o && wb_ack_i;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                         input logic [7:0] edat, input logic eerr);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_valid = 1'b1;
        sb_q.push_back({eerr, edat});
        wait_accept();
    endtask

    task automatic collect(input string tag);
        int         n = 0;
        logic [8:0] exp;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h000;
        check({tag, "_dat"}, {24'd0, rsp_dat}, {24'd0, exp[7:0]});
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp[8]});
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h11] = 8'h02;
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; s_en = 1'b1; spur_ack = 1'b0;

        // Reset state
        #12;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_adr", {24'd0, wb_adr_o}, 32'd0);
        check("rst_dat_o", {24'd0, wb_dat_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_dat", {24'd0, rsp_dat}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Spurious ack while idle has no effect
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        tick();
        check("spur_idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("spur_idle_rsp", {31'd0, rsp_valid}, 32'd0);

        // Write, cycle by cycle
        issue(1'b1, 8'h10, 8'h02, 8'h00, 1'b0);
        check("wr_cyc", {31'd0, wb_cyc_o}, 32'd1);
        check("wr_stb", {31'd0, wb_stb_o}, 32'd1);
        check("wr_we", {31'd0, wb_we_o}, 32'd1);
        check("wr_adr", {24'd0, wb_adr_o}, 32'h10);
        check("wr_dat_o", {24'd0, wb_dat_o}, 32'h02);
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_not_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("wr_cyc_2nd", {31'd0, wb_cyc_o}, 32'd1);
        check("wr_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("wr_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        collect("wr");
        check("wr_mem", {24'd0, mem[8'h10]}, 32'h02);

        // Read
        issue(1'b0, 8'h11, 8'h00, 8'h02, 1'b0);
        tick();
        tick();
        check("rd_stb_after_ack", {31'd0, wb_stb_o}, 32'd0);
        collect("rd");

        // Response backpressure with a pending command
        issue(1'b0, 8'h10, 8'h00, 8'h02, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        cmd_we = 1'b0; cmd_adr = 8'h20; cmd_dat = 8'h00; cmd_valid = 1'b1;
        sb_q.push_back({1'b0, 8'h5A});
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_dat", {24'd0, rsp_dat}, 32'h02);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
            tick();
        end
        collect("bp_first");
        wait_accept();
        collect("bp_next");

        // Back-to-back with cmd_valid held
        fork
            begin
                issue(1'b1, 8'h30, 8'hA5, 8'h00, 1'b0);
                issue(1'b0, 8'h21, 8'h00, 8'hC3, 1'b0);
                issue(1'b0, 8'h30, 8'h00, 8'hA5, 1'b0);
            end
            begin
                collect("b2b_0");
                collect("b2b_1");
                collect("b2b_2");
            end
        join
        check("b2b_sb_drained", sb_q.size(), 32'd0);

        // Slave never acks
        s_en = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        issue(1'b0, 8'h40, 8'h00, 8'hFF, 1'b1);
        n = 0;
        while (wb_cyc_o && n < 40) begin
            tick();
            n++;
        end
        check("to_bus_cycles", n, 32'd16);
        collect("to");
        issue(1'b0, 8'h40, 8'h00, 8'hFF, 1'b1);
`else
        issue(1'b0, 8'h40, 8'h00, 8'hFF, 1'b1);
        repeat (40) tick();
        check("noto_cyc_held", {31'd0, wb_cyc_o}, 32'd1);
        check("noto_no_rsp", {31'd0, rsp_valid}, 32'd0);
`endif

        // Reset mid-BUS
        check("mid_stb_pre", {31'd0, wb_stb_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_cyc_async", {31'd0, wb_cyc_o}, 32'd0);
        check("mid_stb_async", {31'd0, wb_stb_o}, 32'd0);
        check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        sb_q.delete();
        s_en = 1'b1;
        #10;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        issue(1'b0, 8'h11, 8'h00, 8'h02, 1'b0);
        collect("post_rst_rd");

        check("protocol_viol", n_viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
